traffic_light_monitor: RTL and testbench
========================================

Name: traffic_light_monitor

Overview:
- Passive checker on the light-output side of the traffic light controller.
- Samples the nslight/ewlight pair every clock, decodes it to a phase, and tracks the NSgreen -> NSyellow -> EWgreen -> EWyellow cycle.
- Flags illegal encodings, out-of-order phases and wrong phase durations; counts completed cycles and errors.
- Instantiated beside the controller in the system top and in the bench; it never drives the lights.

Parameters:
- GREEN_CYCLES, 6, required dwell in cycles of each green phase.
- YELLOW_CYCLES, 3, required dwell in cycles of each yellow phase.
- ALLRED_CYCLES, 1, required dwell of the all-red phase (used only with the optional feature).
- CNT_W, 8, width of the dwell counter, cycle_count and err_count.

Ports:
- clk  in  1  clock; all logic on the rising edge
- reset  in  1  asynchronous, active-low reset
- nslight  in  3  north-south light, one-hot {RED=100, YELLOW=010, GREEN=001}
- ewlight  in  3  east-west light, same encoding
- clr_err  in  1  synchronous clear of err_sticky and err_count
- phase  out  2  tracked phase: 00 NSgreen, 01 NSyellow, 10 EWgreen, 11 EWyellow
- phase_valid  out  1  monitor is locked to a legal phase
- in_allred  out  1  all-red clearance phase active (tied 0 without the macro)
- err_encoding  out  1  one-cycle pulse: illegal light pair
- err_sequence  out  1  one-cycle pulse: legal but out-of-order phase
- err_duration  out  1  one-cycle pulse: dwell mismatch
- err_sticky  out  1  OR of all error pulses since reset or clear
- err_count  out  CNT_W  number of error cycles, saturating
- cycle_done  out  1  one-cycle pulse on the EWyellow -> NSgreen transition
- cycle_count  out  CNT_W  completed cycles, wraps modulo 2^CNT_W

Behaviour:
- Reset (reset=0, asynchronous, also mid-operation): FSM=SYNC, all outputs 0, dwell=0, first_phase=1.
- All outputs are registered. A sample taken at edge N is reflected immediately after edge N (latency 1 edge).
- Legal pairs (ns,ew): NSgreen (001,100), NSyellow (010,100), EWgreen (100,001), EWyellow (100,010). Every other pair is illegal.
- SYNC state:
  - Illegal pair: stay in SYNC, no error reported.
  - Legal pair: go to TRACK; phase=decoded value, phase_valid=1, dwell=1, first_phase=1.
- TRACK state, per sample:
  - Illegal pair: err_encoding=1; go to SYNC; phase_valid=0, phase holds its last value.
  - Same phase:
    - dwell increments, saturating at 2^CNT_W-1.
    - When dwell becomes required+1 and first_phase=0: err_duration pulses exactly once per phase.
  - Next expected phase:
    - If first_phase=0 and dwell != required: err_duration=1. An over-long phase already flagged is not flagged again.
    - Then phase=new, dwell=1, first_phase=0.
    - EWyellow -> NSgreen: cycle_done=1 and cycle_count+1, including when a duration error is flagged on the same edge.
  - Other legal phase: err_sequence=1; phase=new, dwell=1, first_phase=1 (resync; no duration check on the partial phase).
- The first phase after SYNC or a resync is never duration-checked. Its exit is checked only for ordering.
- Error bookkeeping:
  - Any error pulse sets err_sticky.
  - err_count increments by 1 per cycle with any error, saturating at 2^CNT_W-1. Multiple simultaneous errors count once.
  - clr_err=1 clears err_sticky and err_count. If clr_err and an error occur in the same cycle, the error wins: err_sticky=1, err_count=1.

Optional Feature:
- Macro: TRAFFIC_LIGHT_ALLRED_PHASE_EN.
- Defined:
  - Pair (100,100) is legal, but only directly after NSyellow or EWyellow.
  - During all-red: in_allred=1, phase holds the preceding yellow value.
  - All-red dwell must equal ALLRED_CYCLES (same duration rules as other phases).
  - The only legal exit is the opposing green. Exiting to any other legal phase is err_sequence. EWyellow -> all-red -> NSgreen counts as cycle_done.
  - Direct yellow -> opposing green remains legal.
  - All-red entered from SYNC or from a green is err_sequence (from TRACK) or is ignored (in SYNC).
- Undefined: (100,100) is illegal (err_encoding) and in_allred is tied 0.

Test Plan:
- Release reset; drive NSG 6 / NSY 3 / EWG 6 / EWY 3 twice, then NSG 1 cycle -> no error pulses; cycle_done pulses once per EWY->NSG transition; cycle_count=2; phase_valid=1 from the first sample.
- One full legal cycle, then NSG held 7 cycles -> err_duration pulses once at the 7th NSG sample; no second pulse on the NSY transition; err_sticky=1; err_count=1.
- Mid-cycle drive (001,001) -> err_encoding=1, phase_valid=0. Then EWG 2 cycles, EWY 3 cycles -> TRACK resumes with no err_duration on the short EWG.
- After a checked NSG phase, go directly to EWG -> err_sequence=1, phase=10. Assert clr_err in the same cycle as an error -> err_sticky=1, err_count=1.
- Assert reset asynchronously mid-EWG -> all outputs 0 before the next clk edge. Release reset -> re-lock on the first legal sample.
- With TRAFFIC_LIGHT_ALLRED_PHASE_EN: NSY 3 / (100,100) 1 / EWG 6 -> in_allred=1 for one cycle, no errors. Without the macro, the same stimulus gives err_encoding on the all-red sample.

Source files
------------

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor: passive checker of the NS/EW light outputs.
// Define TRAFFIC_LIGHT_ALLRED_PHASE_EN to accept an all-red clearance phase.
module traffic_light_monitor #(
  parameter int GREEN_CYCLES  = 6,
  parameter int YELLOW_CYCLES = 3,
  parameter int ALLRED_CYCLES = 1,
  parameter int CNT_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       nslight,
  input  logic [2:0]       ewlight,
  input  logic             clr_err,
  output logic [1:0]       phase,
  output logic             phase_valid,
  output logic             in_allred,
  output logic             err_encoding,
  output logic             err_sequence,
  output logic             err_duration,
  output logic             err_sticky,
  output logic [CNT_W-1:0] err_count,
  output logic             cycle_done,
  output logic [CNT_W-1:0] cycle_count
);

`ifdef TRAFFIC_LIGHT_ALLRED_PHASE_EN
  localparam bit AR_EN = 1'b1;
`else
  localparam bit AR_EN = 1'b0;
`endif

  localparam logic [CNT_W-1:0] MAXV = '1;
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W:0] REQ_G = (CNT_W+1)'(GREEN_CYCLES);
  localparam logic [CNT_W:0] REQ_Y = (CNT_W+1)'(YELLOW_CYCLES);
  localparam logic [CNT_W:0] REQ_A = (CNT_W+1)'(ALLRED_CYCLES);

  typedef enum logic {S_SYNC, S_TRACK} state_t;

  state_t           r_state, w_state_nx;
  logic [1:0]       r_phase, w_phase_nx;
  logic             r_allred, w_allred_nx;
  logic             r_valid, w_valid_nx;
  logic [CNT_W-1:0] r_dwell, w_dwell_nx;
  logic             r_first, w_first_nx;
  logic             r_enc, w_enc_nx;
  logic             r_seq, w_seq_nx;
  logic             r_dur, w_dur_nx;
  logic             r_done, w_done_nx;
  logic             r_sticky, w_sticky_nx;
  logic [CNT_W-1:0] r_ecnt, w_ecnt_nx;
  logic [CNT_W-1:0] r_ccnt, w_ccnt_nx;

  logic [5:0]       w_pair;
  logic             w_legal;
  logic             w_ar;
  logic [1:0]       w_dec;
  logic [CNT_W:0]   w_req;
  logic [CNT_W:0]   w_dwell_q;
  logic [1:0]       w_opp;
  logic [1:0]       w_nxt;
  logic             w_same;
  logic             w_expect;
  logic             w_short;
  logic             w_at_req;
  logic             w_any;

  assign w_pair = {nslight, ewlight};
  assign w_ar   = AR_EN && (w_pair == 6'b100_100);

  always_comb begin
    w_legal = 1'b1;
    w_dec   = 2'b00;
    unique case (1'b1)
      (w_pair == 6'b001_100): w_dec = 2'b00;
      (w_pair == 6'b010_100): w_dec = 2'b01;
      (w_pair == 6'b100_001): w_dec = 2'b10;
      (w_pair == 6'b100_010): w_dec = 2'b11;
      default:                w_legal = 1'b0;
    endcase
  end

  always_comb begin
    if (r_allred)        w_req = REQ_A;
    else if (r_phase[0]) w_req = REQ_Y;
    else                 w_req = REQ_G;
  end

  // all-red keeps the yellow (or green) it came from; exit is the other green
  assign w_opp     = {~r_phase[1], 1'b0};
  assign w_nxt     = r_phase + 2'd1;
  assign w_dwell_q = {1'b0, r_dwell};
  assign w_short   = !r_first && (w_dwell_q < w_req);
  assign w_at_req  = !r_first && (w_dwell_q == w_req);

  assign w_same = r_allred ? w_ar
                           : (w_legal && (w_dec == r_phase));
  assign w_expect = r_allred
                  ? (w_legal && (w_dec == w_opp))
                  : ((w_legal && (w_dec == w_nxt))
                     || (r_phase[0] && w_ar));

  always_comb begin
    w_state_nx  = r_state;
    w_phase_nx  = r_phase;
    w_allred_nx = r_allred;
    w_valid_nx  = r_valid;
    w_dwell_nx  = r_dwell;
    w_first_nx  = r_first;
    w_enc_nx    = 1'b0;
    w_seq_nx    = 1'b0;
    w_dur_nx    = 1'b0;
    w_done_nx   = 1'b0;
    unique case (r_state)
      S_SYNC: begin
        if (w_legal) begin
          w_state_nx  = S_TRACK;
          w_phase_nx  = w_dec;
          w_allred_nx = 1'b0;
          w_valid_nx  = 1'b1;
          w_dwell_nx  = ONE;
          w_first_nx  = 1'b1;
        end
      end
      S_TRACK: begin
        if (!(w_legal || w_ar)) begin
          w_enc_nx    = 1'b1;
          w_state_nx  = S_SYNC;
          w_valid_nx  = 1'b0;
          w_allred_nx = 1'b0;
        end else if (w_same) begin
          if (r_dwell != MAXV) w_dwell_nx = r_dwell + ONE;
          w_dur_nx = w_at_req;
        end else begin
          w_dwell_nx  = ONE;
          w_allred_nx = w_ar;
          if (!w_ar) w_phase_nx = w_dec;
          if (w_expect) begin
            w_dur_nx   = w_short;
            w_first_nx = 1'b0;
            w_done_nx  = (r_phase == 2'b11) && w_legal
                         && (w_dec == 2'b00);
          end else begin
            w_seq_nx   = 1'b1;
            w_first_nx = 1'b1;
          end
        end
      end
      default: w_state_nx = S_SYNC;
    endcase
  end

  assign w_any = w_enc_nx | w_seq_nx | w_dur_nx;

  always_comb begin
    w_sticky_nx = r_sticky;
    w_ecnt_nx   = r_ecnt;
    if (w_any) begin
      w_sticky_nx = 1'b1;
      if (clr_err)              w_ecnt_nx = ONE;
      else if (r_ecnt != MAXV)  w_ecnt_nx = r_ecnt + ONE;
    end else if (clr_err) begin
      w_sticky_nx = 1'b0;
      w_ecnt_nx   = '0;
    end
  end

  assign w_ccnt_nx = w_done_nx ? r_ccnt + ONE : r_ccnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_SYNC;
      r_phase  <= 2'b00;
      r_allred <= 1'b0;
      r_valid  <= 1'b0;
      r_dwell  <= '0;
      r_first  <= 1'b1;
      r_enc    <= 1'b0;
      r_seq    <= 1'b0;
      r_dur    <= 1'b0;
      r_done   <= 1'b0;
      r_sticky <= 1'b0;
      r_ecnt   <= '0;
      r_ccnt   <= '0;
    end else begin
      r_state  <= w_state_nx;
      r_phase  <= w_phase_nx;
      r_allred <= w_allred_nx;
      r_valid  <= w_valid_nx;
      r_dwell  <= w_dwell_nx;
      r_first  <= w_first_nx;
      r_enc    <= w_enc_nx;
      r_seq    <= w_seq_nx;
      r_dur    <= w_dur_nx;
      r_done   <= w_done_nx;
      r_sticky <= w_sticky_nx;
      r_ecnt   <= w_ecnt_nx;
      r_ccnt   <= w_ccnt_nx;
    end
  end

  assign phase        = r_phase;
  assign phase_valid  = r_valid;
  assign err_encoding = r_enc;
  assign err_sequence = r_seq;
  assign err_duration = r_dur;
  assign err_sticky   = r_sticky;
  assign err_count    = r_ecnt;
  assign cycle_done   = r_done;
  assign cycle_count  = r_ccnt;

`ifdef TRAFFIC_LIGHT_ALLRED_PHASE_EN
  assign in_allred = r_allred;
`else
  assign in_allred = 1'b0;
`endif

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb_traffic_light_monitor: directed + random checks of
// traffic_light_monitor against a phase-table reference model.
module tb_traffic_light_monitor;

`ifdef TRAFFIC_LIGHT_ALLRED_PHASE_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  localparam int MAXC = 255;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] nslight;
  logic [2:0] ewlight;
  logic       clr_err;
  logic [1:0] phase;
  logic       phase_valid;
  logic       in_allred;
  logic       err_encoding;
  logic       err_sequence;
  logic       err_duration;
  logic       err_sticky;
  logic [7:0] err_count;
  logic       cycle_done;
  logic [7:0] cycle_count;

  always #5 clk = ~clk;

  traffic_light_monitor #(
    .GREEN_CYCLES (6),
    .YELLOW_CYCLES(3),
    .ALLRED_CYCLES(1),
    .CNT_W        (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .nslight     (nslight),
    .ewlight     (ewlight),
    .clr_err     (clr_err),
    .phase       (phase),
    .phase_valid (phase_valid),
    .in_allred   (in_allred),
    .err_encoding(err_encoding),
    .err_sequence(err_sequence),
    .err_duration(err_duration),
    .err_sticky  (err_sticky),
    .err_count   (err_count),
    .cycle_done  (cycle_done),
    .cycle_count (cycle_count)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // phase index: 0 NSG, 1 NSY, 2 EWG, 3 EWY, 4 all-red
  logic [5:0] pat [5] = '{6'b001_100, 6'b010_100,
                          6'b100_001, 6'b100_010,
                          6'b100_100};
  int req [5] = '{6, 3, 6, 3, 1};

  bit m_lock;
  int m_ph;
  int m_out;
  int m_dwell;
  bit m_first;
  bit m_enc, m_seq, m_dur, m_done, m_sticky;
  int m_ec, m_cc;

  function automatic int decode(input logic [5:0] p);
    for (int i = 0; i < 4; i++)
      if (p == pat[i]) return i;
    if (AR && p == pat[4]) return 4;
    return -1;
  endfunction

  function automatic bit expected_next(input int cur,
                                       input int held,
                                       input int p);
    if (cur == 4) return p == ((held < 2) ? 2 : 0);
    if (p == (cur + 1) % 4) return 1'b1;
    return (p == 4) && (cur % 2 == 1);
  endfunction

  task automatic m_reset();
    m_lock = 0; m_ph = 0; m_out = 0; m_dwell = 0;
    m_first = 1; m_enc = 0; m_seq = 0; m_dur = 0;
    m_done = 0; m_sticky = 0; m_ec = 0; m_cc = 0;
  endtask

  task automatic m_step(input logic [5:0] pr, input logic clr);
    int p;
    p = decode(pr);
    m_enc = 0; m_seq = 0; m_dur = 0; m_done = 0;
    if (!m_lock) begin
      if (p >= 0 && p < 4) begin
        m_lock = 1; m_ph = p; m_out = p;
        m_dwell = 1; m_first = 1;
      end
    end else if (p < 0) begin
      m_enc = 1; m_lock = 0;
    end else if (p == m_ph) begin
      if (m_dwell < MAXC) m_dwell++;
      if (!m_first && m_dwell == req[m_ph] + 1) m_dur = 1;
    end else if (expected_next(m_ph, m_out, p)) begin
      if (!m_first && m_dwell < req[m_ph]) m_dur = 1;
      if (m_out == 3 && p == 0) begin
        m_done = 1;
        m_cc = (m_cc + 1) % 256;
      end
      m_ph = p;
      if (p < 4) m_out = p;
      m_dwell = 1; m_first = 0;
    end else begin
      m_seq = 1; m_ph = p;
      if (p < 4) m_out = p;
      m_dwell = 1; m_first = 1;
    end
    if (m_enc || m_seq || m_dur) begin
      m_sticky = 1;
      m_ec = clr ? 1 : ((m_ec < MAXC) ? m_ec + 1 : m_ec);
    end else if (clr) begin
      m_sticky = 0; m_ec = 0;
    end
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic chk_all();
    chk("phase",     32'(phase),        32'(m_out));
    chk("valid",     32'(phase_valid),  32'(m_lock));
    chk("allred",    32'(in_allred),
        32'(m_lock && m_ph == 4));
    chk("err_enc",   32'(err_encoding), 32'(m_enc));
    chk("err_seq",   32'(err_sequence), 32'(m_seq));
    chk("err_dur",   32'(err_duration), 32'(m_dur));
    chk("sticky",    32'(err_sticky),   32'(m_sticky));
    chk("err_count", 32'(err_count),    32'(m_ec));
    chk("done",      32'(cycle_done),   32'(m_done));
    chk("cyc_count", 32'(cycle_count),  32'(m_cc));
  endtask

  task automatic step(input logic [5:0] pr, input logic clr);
    {nslight, ewlight} = pr;
    clr_err = clr;
    @(posedge clk);
    m_step(pr, clr);
    #1;
    chk_all();
  endtask

  task automatic run(input int ph, input int n);
    for (int i = 0; i < n; i++) step(pat[ph], 1'b0);
  endtask

  initial begin
    reset   = 1'b0;
    nslight = 3'b000;
    ewlight = 3'b000;
    clr_err = 1'b0;
    m_reset();
    #1;
    chk_all();
    @(negedge clk);
    reset = 1'b1;

    // two clean cycles, then one NSG sample
    run(0, 1);
    chk("lock_first", 32'(phase_valid), 32'd1);
    run(0, 5); run(1, 3); run(2, 6); run(3, 3);
    run(0, 6); run(1, 3); run(2, 6); run(3, 3);
    run(0, 1);
    chk("two_cycles", 32'(cycle_count), 32'd2);
    chk("clean_run", 32'(err_sticky), 32'd0);

    // over-long NSG after a full legal cycle
    run(0, 5); run(1, 3); run(2, 6); run(3, 3);
    run(0, 6);
    chk("nsg6_ok", 32'(err_duration), 32'd0);
    run(0, 1);
    chk("nsg7_dur", 32'(err_duration), 32'd1);
    run(1, 1);
    chk("nsy_nodur", 32'(err_duration), 32'd0);
    chk("ec_one", 32'(err_count), 32'd1);

    // illegal pair mid-cycle, then short EWG resync
    run(1, 2);
    step(6'b001_001, 1'b0);
    chk("enc_pulse", 32'(err_encoding), 32'd1);
    chk("enc_unlock", 32'(phase_valid), 32'd0);
    run(2, 2); run(3, 3);
    chk("short_ok", 32'(err_count), 32'd2);
    run(0, 6);

    // skip NSY with clear on the same edge
    step(pat[2], 1'b1);
    chk("seq_pulse", 32'(err_sequence), 32'd1);
    chk("seq_phase", 32'(phase), 32'd2);
    chk("clr_sticky", 32'(err_sticky), 32'd1);
    chk("clr_count", 32'(err_count), 32'd1);

    // asynchronous reset mid-EWG
    run(2, 3);
    #2;
    reset = 1'b0;
    #1;
    m_reset();
    chk_all();
    @(negedge clk);
    reset = 1'b1;
    run(3, 1);
    chk("relock", 32'(phase_valid), 32'd1);
    run(3, 1);

    // all-red clearance between NSY and EWG
    run(0, 6); run(1, 3);
    step(pat[4], 1'b0);
    chk("ar_flag", 32'(in_allred), 32'(AR));
    chk("ar_enc", 32'(err_encoding), 32'(!AR));
    run(2, 6);

    // randomized segments
    begin
      int cur;
      cur = 2;
      repeat (300) begin
        int r;
        int len;
        int nx;
        logic [5:0] p;
        r = $urandom_range(0, 99);
        if (r < 70) begin
          nx = (cur + 1) % 4;
          len = ($urandom_range(0, 3) == 0)
                ? $urandom_range(1, 8) : req[nx];
          p = pat[nx];
          cur = nx;
        end else if (r < 82) begin
          nx = $urandom_range(0, 3);
          len = $urandom_range(1, 7);
          p = pat[nx];
          cur = nx;
        end else if (r < 92) begin
          p = pat[4];
          len = $urandom_range(1, 2);
        end else begin
          p = 6'($urandom);
          len = 1;
        end
        for (int k = 0; k < len; k++)
          step(p, $urandom_range(0, 19) == 0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
